ethernet_frame_controller: RTL
==============================

# ethernet_frame_controller

Sequences the receive-side byte FIFO of the ethernet block: pops bytes while the PHY path is initialised, parses the 14-byte MAC header, filters on destination address, and forwards payload bytes to a downstream consumer over a valid/ready stream with first/last framing. Frame boundaries come from a one-cycle end-of-frame pulse from the rx path, since the FIFO carries no delimiters. Sits between the ethernet FIFO (ethernet_rd / ethernet_empty / byte_rx) and the packet consumer.

## Interface
- MAC_ADDR, 48'h02_00_00_00_00_01, station address; byte 0 = bits [47:40], first on wire
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- ethernet_ready  in  1  PHY init complete; no FIFO pops while low
- ethernet_empty  in  1  FIFO empty
- byte_rx  in  8  FIFO head byte, valid combinationally while ethernet_empty=0
- ethernet_rd  out  1  pop strobe; head removed at the clock edge
- frame_end  in  1  one-cycle pulse, asserted no earlier than the cycle after the frame's last FIFO write
- promisc  in  1  accept every destination address
- out_data  out  8  payload byte
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts; transfer = out_valid & out_ready
- out_first / out_last  out  1  marks first / last payload byte of frame
- ethertype  out  16  EtherType of current frame, stable from TYPE exit to next frame
- src_mac  out  48  source address of current frame, same stability
- frames_ok / frames_dropped  out  16  saturating counters
- boundary_error  out  1  sticky: frame_end received while an end was already pending

## Operation
- States: WAIT_INIT, IDLE, DST, SRC, TYPE, PAYLOAD, DROP.
- WAIT_INIT: no pops; -> IDLE when ethernet_ready=1. ethernet_ready falling in any state -> WAIT_INIT next cycle, frame abandoned uncounted, hold register cleared.
- pend_end register: set on frame_end, cleared when the boundary is consumed. frame_end while pend_end=1 sets boundary_error; pend_end stays 1.
- Boundary = ethernet_empty=1 & pend_end=1.
- IDLE: on !ethernet_empty -> DST without popping. Boundary with empty FIFO in IDLE: clear pend_end, no count.
- DST/SRC/TYPE: pop one byte per cycle while !ethernet_empty; 4-bit byte index. DST compares each byte with MAC_ADDR and FF; match = all six equal MAC_ADDR, or all FF, or promisc. SRC shifts into src_mac; TYPE into ethertype (MSB first).
- After 6th DST byte: no match -> DROP; match -> SRC. After 2nd TYPE byte -> PAYLOAD.
- Boundary in DST/SRC/TYPE (runt): frames_dropped+1, clear pend_end, -> IDLE.
- PAYLOAD: one-byte hold register (hold_valid, hold_data, hold_first). Pop when !empty & (!hold_valid | transfer); popped byte loads hold. out_valid = hold_valid & (!ethernet_empty | pend_end). out_last = out_valid & ethernet_empty & pend_end. out_first = hold_first.
- Transfer with out_last: frames_ok+1, clear pend_end, -> IDLE. Boundary with hold_valid=0 (zero-length payload): frames_dropped+1, -> IDLE.
- DROP: pop every cycle while !empty; on boundary frames_dropped+1, clear pend_end, -> IDLE.
- FCS bytes are forwarded as payload; no CRC check.
- Counters saturate at 16'hFFFF.

## Timing
- Reset: state WAIT_INIT, ethernet_rd=0, out_valid=0, out_first=0, out_last=0, out_data=0, ethertype=0, src_mac=0, frames_ok=0, frames_dropped=0, boundary_error=0, pend_end=0, hold_valid=0.
- Header throughput 1 byte/cycle; 14 pops in 14 cycles given non-empty FIFO.
- First payload byte: popped the cycle after last TYPE pop; out_valid the following cycle at earliest.
- out_data/out_first/out_last stable while out_valid=1 & out_ready=0.
- With out_ready held high and FIFO non-empty, 1 payload byte/cycle.
- System constraint: backpressure must not exceed inter-frame gap plus preamble time, else boundaries merge and boundary_error flags it.

## Test plan
- Unicast frame to MAC_ADDR, EtherType 16'h0800, 46-byte payload, out_ready=1 -> 46 transfers, out_first on byte 0, out_last on byte 45, ethertype=16'h0800, frames_ok=1.
- Dest 48'h02_00_00_00_00_02, promisc=0 -> no out_valid, all bytes popped, frames_dropped=1; repeat with promisc=1 -> forwarded, frames_ok=1.
- Broadcast FF..FF with 1-byte payload 8'hA5 -> single transfer with out_first=out_last=1, data 8'hA5.
- Runt: 10 header bytes then frame_end -> frames_dropped=1, state back to IDLE, no out_valid.
- out_ready toggled every other cycle over 20-byte payload -> no byte lost or duplicated, stable data while stalled; two back-to-back frame_end pulses without drain -> boundary_error=1.
- ethernet_ready low for 10 cycles after reset with bytes queued -> ethernet_rd stays 0; reset asserted mid-payload -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/ethernet_frame_controller.sv
// Receive-side sequencer: drains the ethernet byte FIFO, parses the MAC header,
// filters on destination address and streams payload bytes with first/last marks.
//
// state     | meaning
// WAIT_INIT | PHY not ready, no pops
// IDLE      | waiting for the first byte of a frame
// DST/SRC   | popping the destination / source address
// TYPE      | popping the EtherType
// PAYLOAD   | forwarding payload through the one-byte hold register
// DROP      | discarding the rest of a filtered frame
module ethernet_frame_controller #(
    parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ethernet_ready,
    input  logic        ethernet_empty,
    input  logic [7:0]  byte_rx,
    output logic        ethernet_rd,
    input  logic        frame_end,
    input  logic        promisc,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_first,
    output logic        out_last,
    output logic [15:0] ethertype,
    output logic [47:0] src_mac,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_dropped,
    output logic        boundary_error
);

    localparam logic [2:0] WAIT_INIT = 3'd0;
    localparam logic [2:0] IDLE      = 3'd1;
    localparam logic [2:0] DST       = 3'd2;
    localparam logic [2:0] SRC       = 3'd3;
    localparam logic [2:0] TYPE      = 3'd4;
    localparam logic [2:0] PAYLOAD   = 3'd5;
    localparam logic [2:0] DROP      = 3'd6;

    logic [2:0] state;
    logic [3:0] byte_idx;
    logic       uni_ok;
    logic       bc_ok;
    logic       pend_end;
    logic       hold_valid;
    logic [7:0] hold_data;
    logic       hold_first;
    logic       first_pend;

    logic       boundary;
    logic       transfer;
    logic [7:0] mac_byte;
    logic       dst_match;
    logic       pend_clr;
    logic       ok_inc;
    logic       drop_inc;

    assign boundary  = ethernet_empty & pend_end;
    // The held byte is only offered once we know whether it is the last one.
    assign out_valid = hold_valid & (!ethernet_empty | pend_end);
    assign out_last  = out_valid & ethernet_empty & pend_end;
    assign out_first = hold_first;
    assign out_data  = hold_data;
    assign transfer  = out_valid & out_ready;
    assign dst_match = (uni_ok & (byte_rx == mac_byte)) | (bc_ok & (byte_rx == 8'hFF)) | promisc;

    always_comb begin
        mac_byte = 8'h00;
        case (byte_idx[2:0])
            3'd0:    mac_byte = MAC_ADDR[47:40];
            3'd1:    mac_byte = MAC_ADDR[39:32];
            3'd2:    mac_byte = MAC_ADDR[31:24];
            3'd3:    mac_byte = MAC_ADDR[23:16];
            3'd4:    mac_byte = MAC_ADDR[15:8];
            3'd5:    mac_byte = MAC_ADDR[7:0];
            default: mac_byte = 8'h00;
        endcase
    end

    always_comb begin
        ethernet_rd = 1'b0;
        if (ethernet_ready && !ethernet_empty) begin
            case (state)
                DST, SRC, TYPE, DROP: ethernet_rd = 1'b1;
                PAYLOAD:              ethernet_rd = !hold_valid | transfer;
                default:              ethernet_rd = 1'b0;
            endcase
        end
    end

    always_comb begin
        pend_clr = 1'b0;
        ok_inc   = 1'b0;
        drop_inc = 1'b0;
        if (ethernet_ready) begin
            case (state)
                IDLE: pend_clr = boundary;
                DST, SRC, TYPE, DROP: begin
                    pend_clr = boundary;
                    drop_inc = boundary;
                end
                PAYLOAD: begin
                    if (transfer && out_last) begin
                        pend_clr = 1'b1;
                        ok_inc   = 1'b1;
                    end else if (boundary && !hold_valid) begin
                        pend_clr = 1'b1;
                        drop_inc = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= WAIT_INIT;
            byte_idx       <= 4'd0;
            uni_ok         <= 1'b0;
            bc_ok          <= 1'b0;
            pend_end       <= 1'b0;
            hold_valid     <= 1'b0;
            hold_data      <= 8'h00;
            hold_first     <= 1'b0;
            first_pend     <= 1'b0;
            ethertype      <= 16'h0000;
            src_mac        <= 48'h0;
            frames_ok      <= 16'h0000;
            frames_dropped <= 16'h0000;
            boundary_error <= 1'b0;
        end else begin
            pend_end <= frame_end | (pend_end & !pend_clr);
            if (frame_end && pend_end)
                boundary_error <= 1'b1;
            if (ok_inc && frames_ok != 16'hFFFF)
                frames_ok <= frames_ok + 16'd1;
            if (drop_inc && frames_dropped != 16'hFFFF)
                frames_dropped <= frames_dropped + 16'd1;

            if (!ethernet_ready) begin
                state      <= WAIT_INIT;
                hold_valid <= 1'b0;
                hold_data  <= 8'h00;
                hold_first <= 1'b0;
                first_pend <= 1'b0;
            end else begin
                case (state)
                    WAIT_INIT: state <= IDLE;
                    IDLE: begin
                        if (!ethernet_empty) begin
                            state    <= DST;
                            byte_idx <= 4'd0;
                            uni_ok   <= 1'b1;
                            bc_ok    <= 1'b1;
                        end
                    end
                    DST: begin
                        if (ethernet_rd) begin
                            uni_ok   <= uni_ok & (byte_rx == mac_byte);
                            bc_ok    <= bc_ok & (byte_rx == 8'hFF);
                            byte_idx <= byte_idx + 4'd1;
                            if (byte_idx == 4'd5) begin
                                byte_idx <= 4'd0;
                                state    <= dst_match ? SRC : DROP;
                            end
                        end else if (boundary) begin
                            state <= IDLE;
                        end
                    end
                    SRC: begin
                        if (ethernet_rd) begin
                            src_mac  <= {src_mac[39:0], byte_rx};
                            byte_idx <= byte_idx + 4'd1;
                            if (byte_idx == 4'd5) begin
                                byte_idx <= 4'd0;
                                state    <= TYPE;
                            end
                        end else if (boundary) begin
                            state <= IDLE;
                        end
                    end
                    TYPE: begin
                        if (ethernet_rd) begin
                            ethertype <= {ethertype[7:0], byte_rx};
                            byte_idx  <= byte_idx + 4'd1;
                            if (byte_idx == 4'd1) begin
                                byte_idx   <= 4'd0;
                                first_pend <= 1'b1;
                                state      <= PAYLOAD;
                            end
                        end else if (boundary) begin
                            state <= IDLE;
                        end
                    end
                    PAYLOAD: begin
                        if (ethernet_rd) begin
                            hold_valid <= 1'b1;
                            hold_data  <= byte_rx;
                            hold_first <= first_pend;
                            first_pend <= 1'b0;
                        end else if (transfer) begin
                            hold_valid <= 1'b0;
                            hold_first <= 1'b0;
                        end
                        if ((transfer && out_last) || (boundary && !hold_valid))
                            state <= IDLE;
                    end
                    DROP: begin
                        if (boundary)
                            state <= IDLE;
                    end
                    default: state <= WAIT_INIT;
                endcase
            end
        end
    end

endmodule
